// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   Serial receiver for the colour processor command decoder. Oversamples the
//   Rx line at CLKS_PER_BIT clocks per bit and deframes 11-bit frames:
//   start, 8 data bits LSB first, parity, stop.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (even, >= 4)
//   PARITY_ODD    0: even parity (parity bit = XOR of data), 1: odd parity
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   Rx          asynchronous serial line, idles high
//   data        last correctly received byte, held between frames
//   valid       one-cycle strobe, data is new in this cycle
//   parity_err  one-cycle strobe, parity mismatch on the frame just ended
//   frame_err   one-cycle strobe, stop bit sampled 0
//   busy        high whenever the receiver is not idle
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e          state_q;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic            par_ok_q;
  logic            stop_ok_q;
  logic            done_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            perr_q;
  logic            ferr_q;
  logic            busy_q;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      par_ok_q  <= 1'b0;
      stop_ok_q <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], Rx};
      busy_q <= (state_q != S_IDLE);

      // The stop decision is made at mid-stop-bit; the strobes and the data
      // load follow one cycle later so they line up with busy falling.
      valid_q <= done_q & stop_ok_q & par_ok_q;
      perr_q  <= done_q & ~par_ok_q;
      ferr_q  <= done_q & ~stop_ok_q;
      if (done_q && stop_ok_q && par_ok_q) begin
        data_q <= shift_q;
      end
      done_q <= 1'b0;

      cnt_q <= cnt_q + 1'b1;

      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= S_DATA;
              idx_q   <= '0;
              par_q   <= 1'b0;
            end else begin
              // Line back high at mid-start: a glitch, not a frame.
              state_q <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            par_q   <= par_q ^ rx_s;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
        end

        S_PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_q    <= '0;
            par_ok_q <= (rx_s == (par_q ^ PARITY_ODD));
            state_q  <= S_STOP;
          end
        end

        S_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q     <= '0;
            done_q    <= 1'b1;
            stop_ok_q <= rx_s;
            state_q   <= rx_s ? S_IDLE : S_BREAK;
          end
        end

        S_BREAK: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receiver feeding the colour processor's command decoder. It oversamples the `Rx` line with a fixed clocks-per-bit count and deframes 11-bit frames: start bit, 8 data bits LSB first, parity, stop. Each good byte is delivered as a one-cycle `valid` strobe, and each bad frame raises an error strobe instead. It sits directly between the board `Rx` pin and the colour processor register file.

## Interface
- `CLKS_PER_BIT`, default 32: clock cycles per serial bit; even, ≥ 4.
- `PARITY_ODD`, default 0: 0 selects even parity (parity bit = XOR of data bits), 1 selects odd parity.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `Rx`  in  1  asynchronous serial line; idles high.
- `data`  out  8  last correctly received byte; held between frames.
- `valid`  out  1  one-cycle strobe; `data` is new in this cycle.
- `parity_err`  out  1  one-cycle strobe; parity mismatch on the frame just ended.
- `frame_err`  out  1  one-cycle strobe; stop bit sampled 0.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `Rx` passes through a 2-flop synchronizer; `rx_s` is its output, reset to 1.
- Bit counter `cnt` is $clog2(CLKS_PER_BIT) bits wide and clears on every state entry. Bit index `idx` is 3 bits. A shift register and a running parity XOR accumulate the frame.
- **IDLE**: if `rx_s == 0`, go to START. This is level detection, so back-to-back frames need no idle gap.
- **START**: at `cnt == CLKS_PER_BIT/2-1`, sample `rx_s`. A 0 goes to DATA. A 1 is a glitch: go to IDLE with no strobe.
- **DATA**: every `cnt == CLKS_PER_BIT-1`, shift `rx_s` in at the MSB (so the LSB arrives first) and XOR it into parity. After `idx == 7`, go to PARITY.
- **PARITY**: at `cnt == CLKS_PER_BIT-1`, sample the parity bit and compare it with the accumulated XOR (inverted when `PARITY_ODD`). Go to STOP.
- **STOP**: at `cnt == CLKS_PER_BIT-1`, sample the stop bit, then:
  - stop = 1 and parity OK: load `data`, pulse `valid`, go to IDLE.
  - stop = 1 and parity bad: pulse `parity_err`, leave `data` unchanged, go to IDLE.
  - stop = 0: pulse `frame_err` (and `parity_err` too if parity is also bad), leave `data` unchanged, go to BREAK.
- **BREAK**: wait for `rx_s == 1`, then go to IDLE. `busy` stays high throughout.
- `valid` is never asserted together with either error strobe.

## Timing
- Reset values: `data = 0x00`, `valid = 0`, `parity_err = 0`, `frame_err = 0`, `busy = 0`, FSM in IDLE, `rx_s = 1`, counters 0.
- Let k be the first clock edge at which `rx_s` reads 0, i.e. 2 edges after `Rx` falls.
- Sample points:
  - start bit at k + CLKS_PER_BIT/2;
  - data bit i at k + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT;
  - parity at k + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT;
  - stop at k + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT.
- Strobes are registered and go high on the cycle after the stop sample, for exactly one cycle. With the default CLKS_PER_BIT = 32, that is k+337.
- `busy` rises at k+1. It falls with the strobe cycle, or later if the FSM enters BREAK.
- The receiver returns to IDLE at mid-stop-bit, so a start bit immediately after the stop bit is caught; re-arm margin is ½ bit.
- `rst` asserted mid-frame clears everything immediately. The partial frame is discarded and no strobe is produced.
- A clock drift of ±4 cycles per frame at the default parameter must still sample each bit correctly.

## Test plan
- **Good byte:** reset, then send 0x35 with even parity 0 and stop 1, at 32 cycles per bit. Expect `valid` for one cycle at k+337, `data = 0x35`, no error strobe, and `busy` low afterwards.
- **Parity error:** send 0x4A with parity 0 (correct value is 1). Expect `parity_err` for one cycle, `data` still 0x35, and `valid` never asserted.
- **Framing error:** send 0x5D with correct parity and stop 0, holding `Rx` low 100 more cycles. Expect `frame_err` for one cycle, `busy` high until 2 cycles after `Rx` returns to 1, and `data` unchanged.
- **Glitch rejection:** drive `Rx` low for 5 cycles, then high. Expect `busy` pulses high then low, and no strobe, with `data` unchanged.
- **Back-to-back:** send 0x61 then 0x7E, with the second start bit immediately after the first stop bit. Expect two `valid` strobes, 352 cycles apart, with `data` = 0x61 then 0x7E.
- **Reset mid-frame:** assert `rst = 0` during bit 4 of 0x87, release, then send 0x21. Expect all outputs zero while in reset, no strobe for the aborted frame, then `valid` with `data = 0x21`.
